cpu_trace_emitter: RTL and testbench

Serialises one CPU write-back event per request into the ASCII trace line format that `cpu_checker` parses. Register writes are emitted as `^<time>@<pc>: $<grf> <= <data>#` and memory writes as `^<time>@<pc>: *<addr> <= <data>#`. The block drives the testbench character stream that feeds `cpu_checker`, one byte per accepted handshake. The sending side is a CPU model or trace FIFO.

---
 rtl/cpu_trace_pkg.sv | 31 +++
 rtl/trace_bin2bcd.sv | 47 ++++
 rtl/cpu_trace_emitter.sv | 186 ++++++++++++++++++
 tb/tb_cpu_trace_emitter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// rtl/cpu_trace_pkg.sv - shared ASCII constants, enums and hex digit helper for the trace emitter
package cpu_trace_pkg;

   localparam logic [7:0] ASC_CARET  = 8'h5e;
   localparam logic [7:0] ASC_AT     = 8'h40;
   localparam logic [7:0] ASC_COLON  = 8'h3a;
   localparam logic [7:0] ASC_DOLLAR = 8'h24;
   localparam logic [7:0] ASC_STAR   = 8'h2a;
   localparam logic [7:0] ASC_LT     = 8'h3c;
   localparam logic [7:0] ASC_EQ     = 8'h3d;
   localparam logic [7:0] ASC_HASH   = 8'h23;
   localparam logic [7:0] ASC_SPACE  = 8'h20;
   localparam logic [7:0] ASC_ZERO   = 8'h30;

   localparam int TIME_MAX = 9999;
   localparam int BCD_CYCLES = 14;

   typedef enum logic {REG, MEM} kind_t;

   typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

   typedef enum logic [3:0] {
      CARET, TIME, AT, PC, COLON, SP0, MARK, GRF_ADDR, SP1, LT, EQ, SP2, DATA, HASH
   } field_t;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
      // 8'h57 + 10 = 'a'
      return (nibble < 4'd10) ? (ASC_ZERO + {4'h0, nibble}) : (8'h57 + {4'h0, nibble});
   endfunction

endpackage

// File: rtl/trace_bin2bcd.sv
// rtl/trace_bin2bcd.sv - sequential double-dabble, 14-bit binary to 4 BCD digits in 14 cycles
module trace_bin2bcd
   import cpu_trace_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [13:0] bin,
   output logic        done,
   output logic [15:0] bcd
);

   logic [29:0] sr_q, sr_d, adj;
   logic [3:0]  cnt_q, cnt_d;

   always_comb begin
      adj = sr_q;
      for (int i = 0; i < 4; i++) begin
         if (adj[14+4*i +: 4] >= 4'd5)
            adj[14+4*i +: 4] = adj[14+4*i +: 4] + 4'd3;
      end
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (start) begin
         sr_d  = {16'h0000, bin};
         cnt_d = 4'(BCD_CYCLES);
      end else if (cnt_q != 4'd0) begin
         sr_d  = {adj[28:0], 1'b0};
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   // Pulses during the final shift cycle; bcd holds the result from the next cycle on.
   assign done = (cnt_q == 4'd1);
   assign bcd  = sr_q[29:14];

endmodule

// File: rtl/cpu_trace_emitter.sv
// rtl/cpu_trace_emitter.sv - serialises one write-back event into an ASCII trace line
// Optional CPU_TRACE_SPACES_EN: emit the three separator spaces.
module cpu_trace_emitter
   import cpu_trace_pkg::*;
#(
   parameter int TIME_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_kind,
   input  logic [TIME_W-1:0] req_time,
   input  logic [31:0]       req_pc,
   input  logic [4:0]        req_grf,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_data,
   output logic [7:0]        char_out,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              frame_last
);

`ifdef CPU_TRACE_SPACES_EN
   localparam logic SPACES = 1'b1;
`else
   localparam logic SPACES = 1'b0;
`endif

   state_t      state_q, state_d;
   field_t      field_q, field_d, field_nxt;
   logic [2:0]  idx_q, idx_d, idx_last, idx_first;
   kind_t       kind_q;
   logic [31:0] pc_q, addr_q, data_q;
   logic [4:0]  grf_q;

   logic        accept, conv_done;
   logic [13:0] time_sat;
   logic [15:0] bcd;
   logic [2:0]  time_first;
   logic [1:0]  grf_tens;
   logic [3:0]  grf_ones;
   logic [7:0]  ch;

   assign accept   = req_valid && req_ready;
   assign time_sat = (req_time > TIME_W'(TIME_MAX)) ? 14'(TIME_MAX) : req_time[13:0];

   trace_bin2bcd u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (accept),
      .bin   (time_sat),
      .done  (conv_done),
      .bcd   (bcd)
   );

   // Leading-zero suppression: start at the first non-zero digit, always keep the units digit.
   assign time_first = (bcd[15:12] != 4'd0) ? 3'd0 :
                       (bcd[11:8]  != 4'd0) ? 3'd1 :
                       (bcd[7:4]   != 4'd0) ? 3'd2 : 3'd3;

   always_comb begin
      grf_tens = 2'd0;
      grf_ones = grf_q[3:0];
      if (grf_q >= 5'd30) begin
         grf_tens = 2'd3;
         grf_ones = 4'(grf_q - 5'd30);
      end else if (grf_q >= 5'd20) begin
         grf_tens = 2'd2;
         grf_ones = 4'(grf_q - 5'd20);
      end else if (grf_q >= 5'd10) begin
         grf_tens = 2'd1;
         grf_ones = 4'(grf_q - 5'd10);
      end
   end

   always_comb begin
      ch = 8'h00;
      case (field_q)
         CARET:    ch = ASC_CARET;
         TIME:     ch = ASC_ZERO + {4'h0, 4'(bcd >> {~idx_q[1:0], 2'b00})};
         AT:       ch = ASC_AT;
         PC:       ch = hex_ascii(4'(pc_q >> {~idx_q, 2'b00}));
         COLON:    ch = ASC_COLON;
         SP0, SP1, SP2: ch = ASC_SPACE;
         MARK:     ch = (kind_q == MEM) ? ASC_STAR : ASC_DOLLAR;
         GRF_ADDR: begin
            if (kind_q == MEM)
               ch = hex_ascii(4'(addr_q >> {~idx_q, 2'b00}));
            else if (idx_q == 3'd0)
               ch = ASC_ZERO + {6'h00, grf_tens};
            else
               ch = ASC_ZERO + {4'h0, grf_ones};
         end
         LT:       ch = ASC_LT;
         EQ:       ch = ASC_EQ;
         DATA:     ch = hex_ascii(4'(data_q >> {~idx_q, 2'b00}));
         HASH:     ch = ASC_HASH;
         default:  ch = 8'h00;
      endcase
   end

   always_comb begin
      idx_last = 3'd0;
      case (field_q)
         TIME:      idx_last = 3'd3;
         PC, DATA:  idx_last = 3'd7;
         GRF_ADDR:  idx_last = (kind_q == MEM) ? 3'd7 : 3'd1;
         default:   idx_last = 3'd0;
      endcase
      field_nxt = HASH;
      case (field_q)
         CARET:    field_nxt = TIME;
         TIME:     field_nxt = AT;
         AT:       field_nxt = PC;
         PC:       field_nxt = COLON;
         COLON:    field_nxt = SPACES ? SP0 : MARK;
         SP0:      field_nxt = MARK;
         MARK:     field_nxt = GRF_ADDR;
         GRF_ADDR: field_nxt = SPACES ? SP1 : LT;
         SP1:      field_nxt = LT;
         LT:       field_nxt = EQ;
         EQ:       field_nxt = SPACES ? SP2 : DATA;
         SP2:      field_nxt = DATA;
         default:  field_nxt = HASH;
      endcase
      idx_first = 3'd0;
      if (field_nxt == TIME)
         idx_first = time_first;
      else if (field_nxt == GRF_ADDR && kind_q == REG && grf_tens == 2'd0)
         idx_first = 3'd1;
   end

   always_comb begin
      state_d = state_q;
      field_d = field_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: if (req_valid) state_d = CONV;
         CONV: if (conv_done) begin
            state_d = EMIT;
            field_d = CARET;
            idx_d   = 3'd0;
         end
         EMIT: if (char_ready) begin
            if (field_q == HASH) begin
               state_d = IDLE;
            end else if (idx_q != idx_last) begin
               idx_d = idx_q + 3'd1;
            end else begin
               field_d = field_nxt;
               idx_d   = idx_first;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         field_q <= CARET;
         idx_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         idx_q   <= idx_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         kind_q <= kind_t'(req_kind);
         pc_q   <= req_pc;
         grf_q  <= req_grf;
         addr_q <= req_addr;
         data_q <= req_data;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign char_valid = (state_q == EMIT);
   assign char_out   = char_valid ? ch : 8'h00;
   assign frame_last = char_valid && (field_q == HASH);

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// tb/tb_cpu_trace_emitter.sv - directed self-checking bench for cpu_trace_emitter
module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_kind = 1'b0;
   logic [13:0] req_time = '0;
   logic [31:0] req_pc = '0;
   logic [4:0]  req_grf = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_data = '0;
   logic [7:0]  char_out;
   logic        char_valid;
   logic        char_ready = 1'b1;
   logic        frame_last;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cpu_trace_emitter #(.TIME_W(14)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_kind   (req_kind),
      .req_time   (req_time),
      .req_pc     (req_pc),
      .req_grf    (req_grf),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .char_out   (char_out),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .frame_last (frame_last)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic string frame_str(input bit kind, input int t, input logic [31:0] pc,
                                       input logic [4:0] grf, input logic [31:0] addr,
                                       input logic [31:0] data);
      int    ts;
      string sp;
`ifdef CPU_TRACE_SPACES_EN
      sp = " ";
`else
      sp = "";
`endif
      ts = (t > 9999) ? 9999 : t;
      if (kind)
         return $sformatf("^%0d@%08h:%s*%08h%s<=%s%08h#", ts, pc, sp, addr, sp, sp, data);
      return $sformatf("^%0d@%08h:%s$%0d%s<=%s%08h#", ts, pc, sp, grf, sp, sp, data);
   endfunction

   // Issue one request at a negedge and verify the first byte appears in cycle N+15.
   task automatic send(input bit kind, input int t, input logic [31:0] pc, input logic [4:0] grf,
                       input logic [31:0] addr, input logic [31:0] data, input bit noise);
      int w = 0;
      int lat;
      while (!req_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_kind  = kind;
      req_time  = t[13:0];
      req_pc    = pc;
      req_grf   = grf;
      req_addr  = addr;
      req_data  = data;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      check("req_ready_busy", 32'(req_ready), 32'd0);
      lat = 1;
      while (!char_valid && lat < 40) begin
         if (noise && lat < 10) begin
            req_valid = 1'b1;
            req_kind  = ~kind;
            req_time  = 14'd1234;
            req_pc    = 32'hdead_beef;
            req_grf   = 5'd17;
            req_addr  = 32'h1111_2222;
            req_data  = 32'h3333_4444;
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      req_valid = 1'b0;
      check("latency", 32'(lat), 32'd15);
   endtask

   // Collect up to stop_at bytes, checking each against exp and output stability while stalled.
   task automatic expect_frame(input string tag, input string exp, input bit bp, input int stop_at);
      int         n = 0;
      int         cyc = 0;
      bit         prev_stall = 1'b0;
      logic [7:0] prev_c = '0;
      logic       prev_l = 1'b0;
      while (n < stop_at && cyc < 2000) begin
         char_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (prev_stall) begin
            check({tag, "_stall_char"}, 32'(char_out), 32'(prev_c));
            check({tag, "_stall_last"}, 32'(frame_last), 32'(prev_l));
         end
         if (!char_valid) begin
            check({tag, "_valid_drop"}, 32'(char_valid), 32'd1);
            break;
         end
         if (char_ready) begin
            check($sformatf("%s_b%0d", tag, n), 32'(char_out), 32'(exp[n]));
            check($sformatf("%s_last%0d", tag, n), 32'(frame_last), 32'(n == exp.len() - 1));
            n++;
            prev_stall = 1'b0;
         end else begin
            prev_stall = 1'b1;
            prev_c     = char_out;
            prev_l     = frame_last;
         end
         @(negedge clk);
         cyc++;
      end
      char_ready = 1'b1;
      check({tag, "_count"}, 32'(n), 32'(stop_at));
      if (stop_at == exp.len()) begin
         check({tag, "_end_valid"}, 32'(char_valid), 32'd0);
         check({tag, "_end_ready"}, 32'(req_ready), 32'd1);
      end
   endtask

   task automatic frame(input string tag, input bit kind, input int t, input logic [31:0] pc,
                        input logic [4:0] grf, input logic [31:0] addr, input logic [31:0] data,
                        input bit noise, input bit bp);
      string exp;
      exp = frame_str(kind, t, pc, grf, addr, data);
      send(kind, t, pc, grf, addr, data, noise);
      expect_frame(tag, exp, bp, exp.len());
   endtask

   initial begin
      string exp;
      repeat (3) @(negedge clk);
      check("rst_char_valid", 32'(char_valid), 32'd0);
      check("rst_char_out", 32'(char_out), 32'd0);
      check("rst_frame_last", 32'(frame_last), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);

      frame("reg12", 1'b0, 12, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd, 1'b0, 1'b0);
      frame("mem9999", 1'b1, 9999, 32'h0000_4ffc, 5'd0, 32'h0000_2ffc, 32'hffff_ffff, 1'b1, 1'b0);
      frame("t0g0", 1'b0, 0, 32'h0040_0000, 5'd0, 32'h0, 32'h0123_4567, 1'b0, 1'b0);
      frame("tsat", 1'b0, 16383, 32'h89ab_cdef, 5'd31, 32'h0, 32'hfedc_ba98, 1'b0, 1'b0);
      frame("t7mem", 1'b1, 7, 32'hffff_fff1, 5'd9, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0);
      frame("t100g10", 1'b0, 100, 32'h0000_3004, 5'd10, 32'h0, 32'h8000_0001, 1'b0, 1'b0);
      frame("bp", 1'b0, 12, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd, 1'b0, 1'b1);

      // Abandon a frame partway through the PC digits.
      exp = frame_str(1'b0, 12, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd);
      send(1'b0, 12, 32'h0000_3000, 5'd5, 32'h0, 32'h0000_abcd, 1'b0);
      expect_frame("rstmid", exp, 1'b0, 7);
      reset = 1'b1;
      @(negedge clk);
      check("rstmid_valid", 32'(char_valid), 32'd0);
      check("rstmid_char", 32'(char_out), 32'd0);
      check("rstmid_ready", 32'(req_ready), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      frame("after_rst", 1'b0, 321, 32'h0000_3008, 5'd23, 32'h0, 32'hcafe_f00d, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
